// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch stage: credit-limited sequential fetch into a {pc, instr} FIFO.
// Optional combinational response bypass when IFU_BYPASS_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    cnt_t          count;
    cnt_t          outstanding;
    cnt_t          discard;

    logic [CW:0]   in_use;
    logic [31:0]   target_pc;
    logic          gnt_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          fifo_valid;
    logic          bypass_valid;
    logic          bypass_take;
    logic          push;
    logic          pop;

    // A slot is reserved at grant time, so queued plus in-flight words never exceed DEPTH.
    assign in_use    = {1'b0, count} + {1'b0, outstanding};
    assign mem_req   = reset && !redirect && (in_use < (CW+1)'(DEPTH));
    assign mem_addr  = fetch_pc;
    assign target_pc = {redirect_pc[31:2], 2'b00};

    assign gnt_fire   = mem_req && mem_gnt;
    assign rsp_fire   = mem_rvalid && (outstanding != '0);
    assign rsp_keep   = rsp_fire && (discard == '0) && !redirect;
    assign fifo_valid = (count != '0);

`ifdef IFU_BYPASS_EN
    assign bypass_valid = !fifo_valid && rsp_keep;
`else
    assign bypass_valid = 1'b0;
`endif

    assign bypass_take = bypass_valid && instr_ready;
    assign push        = rsp_keep && !bypass_take;
    assign pop         = fifo_valid && instr_ready && !redirect;
    assign instr_valid = fifo_valid || bypass_valid;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (fifo_valid) begin
            instr    = fifo_data[rd_ptr];
            instr_pc = fifo_pc[rd_ptr];
        end else if (bypass_valid) begin
            instr    = mem_rdata;
            instr_pc = resp_pc;
        end
    end

    // A redirect squashes everything still in flight: those words are counted off as they return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - cnt_t'(rsp_fire);
            discard     <= outstanding - cnt_t'(rsp_fire);
        end else begin
            if (gnt_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + cnt_t'(gnt_fire) - cnt_t'(rsp_fire);
            if (rsp_fire && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        (push && !pop) |-> (count < cnt_t'(DEPTH)));
    a_discard_bounded : assert property (@(posedge clk) disable iff (!reset)
        discard <= outstanding);
    a_credit_bounded : assert property (@(posedge clk) disable iff (!reset)
        in_use <= (CW+1)'(DEPTH));

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Prefetching instruction fetch stage sitting directly upstream of the single-cycle core datapath. It generates sequential word fetch addresses to a pipelined instruction memory port with request/grant and in-order response handshakes. Returned words go into a small FIFO of {pc, instruction} pairs, which the core drains with a valid/ready handshake. Branch and jump redirects from the core's next-PC logic flush the queue and cancel in-flight responses.

## Interface
- DEPTH, 4: FIFO entries and maximum credits (power of two, ≥2)
- RESET_PC, 32'h0000_0000: first fetch address after reset

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch address, word aligned
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response word valid (in order, ≥1 cycle after grant)
- mem_rdata  in  32  response instruction word
- instr_valid  out  1  instr/instr_pc valid to core
- instr  out  32  instruction at FIFO head
- instr_pc  out  32  PC of instr
- instr_ready  in  1  core consumes head this cycle
- redirect  in  1  branch/jump taken; flush
- redirect_pc  in  32  new fetch target

## Operation
- State: fetch_pc, resp_pc, FIFO (count 0..DEPTH), outstanding (0..DEPTH), discard (0..DEPTH).
- Credit rule: mem_req = reset_deasserted && !redirect && (count + outstanding < DEPTH); mem_addr = fetch_pc.
- Grant: mem_req && mem_gnt → fetch_pc += 4, outstanding += 1.
- Response: mem_rvalid with outstanding = 0 is ignored. Otherwise outstanding -= 1. If discard > 0: discard -= 1 and the word is dropped. Else {resp_pc, mem_rdata} is pushed and resp_pc += 4.
- Pop: instr_valid && instr_ready removes the head.
- Redirect (highest priority): FIFO cleared; fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}; discard = outstanding, after subtracting any response arriving this cycle. A response arriving in the redirect cycle is dropped. No grant is taken because mem_req is low. A pop in the same cycle has no effect beyond the clear.
- Simultaneous push and pop with the FIFO full is legal. The credit rule guarantees a push never overflows.
- Address arithmetic wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. Internally fetch_pc=resp_pc=RESET_PC and all counters are 0.
- First request: mem_req rises in the first cycle after reset deasserts.
- Without bypass, for a grant in cycle N and rvalid in cycle M ≥ N+1, instr_valid is high in cycle M+1.
- Sustained throughput is one instruction per cycle when memory returns one word per cycle and instr_ready stays high.
- Redirect in cycle R: instr_valid is low in R+1. The first request to redirect_pc issues in R+1.
- Reset asserted mid-operation clears all state immediately. In-flight responses after reset release are not tracked; memory must be reset together with this block.

## Configuration
- IFU_BYPASS_EN defined: when the FIFO is empty, discard = 0, and mem_rvalid is high, the response drives instr/instr_pc/instr_valid combinationally in the same cycle. If instr_ready is also high, the word is consumed and not pushed. This gives zero-cycle added latency.
- IFU_BYPASS_EN undefined: all outputs come from FIFO registers, giving one cycle of added latency as above.

## Test plan
- Reset then free-running memory (gnt=1, rvalid one cycle after grant), instr_ready=1 → mem_addr 0,4,8,…; instr_pc 0,4,8 on consecutive cycles; no bubbles after fill.
- instr_ready=0 for 10 cycles → exactly DEPTH=4 grants, then mem_req=0. Release ready → instr_pc 0,4,8,12 drained in order and fetching resumes at 16.
- Three requests in flight, then redirect to 32'h0000_0103 → the three responses are dropped. The next mem_addr is 32'h100, and the first instr_pc after that is 32'h100.
- Redirect in the same cycle as mem_rvalid and a pop → the response is dropped, the FIFO is empty, instr_valid=0 in the next cycle, and there is no underflow.
- fetch_pc=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 with matching instr_pc.
- Assert reset (low) with the FIFO half full and 2 requests outstanding → all outputs return to their reset values asynchronously. After release, fetch restarts at RESET_PC. With IFU_BYPASS_EN, an empty FIFO plus rvalid plus ready gives instr_valid in the same cycle.
